// File: rtl/muldiv_pkg.sv
// Shared constants and FSM encoding for the EX-stage M-extension multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN  = 32;
  localparam int ITERS = 32;
  localparam int CNT_W = $clog2(ITERS);

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_iter_core.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step, driven by the parent FSM.
module div_iter_core
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            init,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt,
  output logic            last
);

  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] count_q;
  logic [XLEN:0]    shifted;
  logic [XLEN:0]    diff;

  always_comb begin
    shifted = {rem_q, quo_q[XLEN-1]};
    diff    = shifted - {1'b0, dvs_q};
    // Non-negative trial difference means this quotient bit is 1; otherwise restore.
    if (!diff[XLEN]) begin
      rem_nxt = diff[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = shifted[XLEN-1:0];
      quo_nxt = {quo_q[XLEN-2:0], 1'b0};
    end
  end

  assign last = (count_q == CNT_W'(ITERS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (init) begin
      count_q <= '0;
    end else if (step) begin
      count_q <= count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      quo_q <= dividend;
      rem_q <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle RV32M execute unit: 32-step shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to resolve all multiplies with a single-cycle 33x33 multiplier.
module ex_muldiv_unit
  import muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  function automatic logic [XLEN-1:0] neg_if32(input logic n, input logic [XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if64(input logic n, input logic [2*XLEN-1:0] v);
    return n ? (~v + 1'b1) : v;
  endfunction

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [XLEN-1:0]   result_q;

  logic [2:0]        f3_q;
  logic [XLEN-1:0]   a_mag_q;
  logic [2*XLEN-1:0] mul_acc_q;
  logic              q_neg_q;
  logic              r_neg_q;

  logic              accept;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              fast_hit;
  logic [XLEN-1:0]   fast_res;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   final_res;
  logic [XLEN-1:0]   quo_nxt, rem_nxt;
  logic              div_last;
  logic              calc_last;

  assign accept = (state_q == IDLE) && start_i && !flush_i;

  always_comb begin
    a_signed = (funct3_i == F3_MUL) || (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
               (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    b_signed = (funct3_i == F3_MUL) || (funct3_i == F3_MULH) ||
               (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    a_neg    = a_signed && op_a_i[XLEN-1];
    b_neg    = b_signed && op_b_i[XLEN-1];
    a_mag    = neg_if32(a_neg, op_a_i);
    b_mag    = neg_if32(b_neg, op_b_i);
    div_zero = funct3_i[2] && (op_b_i == '0);
    div_ovf  = ((funct3_i == F3_DIV) || (funct3_i == F3_REM)) &&
               (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) && (op_b_i == '1);
    special  = div_zero || div_ovf;
    // Divide-by-zero wins over overflow; only the divisor can be zero in that pair anyway.
    if (div_zero) begin
      special_res = funct3_i[1] ? op_a_i : '1;
    end else begin
      special_res = funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [XLEN:0]     fast_a, fast_b;
  logic signed [2*XLEN+1:0] fast_prod;

  always_comb begin
    fast_a    = {a_signed && op_a_i[XLEN-1], op_a_i};
    fast_b    = {b_signed && op_b_i[XLEN-1], op_b_i};
    fast_prod = fast_a * fast_b;
    fast_hit  = !funct3_i[2];
    fast_res  = (funct3_i == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`else
  assign fast_hit = 1'b0;
  assign fast_res = '0;
`endif

  always_comb begin
    mul_sum     = {1'b0, mul_acc_q[2*XLEN-1:XLEN]} + (mul_acc_q[0] ? {1'b0, a_mag_q} : '0);
    mul_acc_nxt = {mul_sum, mul_acc_q[XLEN-1:1]};
    prod        = neg_if64(q_neg_q, mul_acc_nxt);
    if (f3_q[2]) begin
      final_res = f3_q[1] ? neg_if32(r_neg_q, rem_nxt) : neg_if32(q_neg_q, quo_nxt);
    end else begin
      final_res = (f3_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
  end

  div_iter_core u_div (
    .clk      (clk),
    .reset_n  (reset_n),
    .init     (accept),
    .step     ((state_q == CALC) && f3_q[2]),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_nxt  (quo_nxt),
    .rem_nxt  (rem_nxt),
    .last     (div_last)
  );

  assign calc_last = f3_q[2] ? div_last : (count_q == CNT_W'(ITERS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (special || fast_hit) ? DONE : CALC;
      CALC:    if (calc_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush_i) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        count_q <= '0;
      end else if (state_q == CALC) begin
        count_q <= count_q + 1'b1;
      end
      if (accept && special) begin
        result_q <= special_res;
      end else if (accept && fast_hit) begin
        result_q <= fast_res;
      end else if ((state_q == CALC) && calc_last && !flush_i) begin
        result_q <= final_res;
      end
    end
  end

  // Accept stage: operand magnitudes and sign flags captured once
  always_ff @(posedge clk) begin
    if (accept) begin
      f3_q      <= funct3_i;
      a_mag_q   <= a_mag;
      mul_acc_q <= {{XLEN{1'b0}}, b_mag};
      q_neg_q   <= a_neg ^ b_neg;
      r_neg_q   <= a_neg;
    end else if ((state_q == CALC) && !f3_q[2]) begin
      mul_acc_q <= mul_acc_nxt;
    end
  end

  assign stall_o  = accept || (state_q == CALC);
  assign busy_o   = (state_q == CALC);
  assign done_o   = (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed table-driven bench for ex_muldiv_unit plus flush, reset and back-to-back sequences.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start_i;
  logic [2:0]  funct3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        stall_o;
  logic        busy_o;
  logic        done_o;
  logic [31:0] result_o;

  ex_muldiv_unit dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start_i  (start_i),
    .funct3_i (funct3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .stall_o  (stall_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        spec;
  } vec_t;

  vec_t        vecs[18];
  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] last_res;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic int lat_of(input vec_t v);
    if (v.spec) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (!v.f3[2]) return 1;
`endif
    return 33;
  endfunction

  task automatic run_vec(input vec_t v);
    int   got_lat;
    logic stall_ok;
    @(negedge clk);
    start_i  = 1'b1;
    funct3_i = v.f3;
    op_a_i   = v.a;
    op_b_i   = v.b;
    #1 check({v.name, " stall_at_accept"}, 32'(stall_o), 32'd1);
    @(posedge clk);
    got_lat  = -1;
    stall_ok = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start_i = 1'b0;
        op_a_i  = ~v.a;
        op_b_i  = v.b ^ 32'h5a5a_5a5a;
      end
      #1;
      if (done_o) begin
        got_lat = n;
        break;
      end
      if (!stall_o) stall_ok = 1'b0;
    end
    check({v.name, " latency"}, 32'(got_lat), 32'(lat_of(v)));
    check({v.name, " result"}, result_o, v.exp);
    check({v.name, " stall_in_done"}, 32'(stall_o), 32'd0);
    check({v.name, " stall_before_done"}, 32'(stall_ok), 32'd1);
    @(negedge clk);
    #1;
    check({v.name, " done_pulse"}, 32'(done_o), 32'd0);
    check({v.name, " result_hold"}, result_o, v.exp);
    last_res = v.exp;
  endtask

  initial begin
    int d1, d2, ndone;

    vecs[0]  = '{"MUL_7xm3",      3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{"MULH_min",      3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[2]  = '{"MULHU_max",     3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[3]  = '{"MULHSU_max",    3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vecs[4]  = '{"MUL_shift",     3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0};
    vecs[5]  = '{"MULH_m1xm1",    3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[6]  = '{"DIV_m20_3",     3'd4, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFA, 1'b0};
    vecs[7]  = '{"REM_m20_3",     3'd6, 32'hFFFF_FFEC, 32'h0000_0003, 32'hFFFF_FFFE, 1'b0};
    vecs[8]  = '{"DIV_7_m2",      3'd4, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{"REM_7_m2",      3'd6, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[10] = '{"DIVU_100_7",    3'd5, 32'd100,       32'd7,         32'd14,        1'b0};
    vecs[11] = '{"REMU_100_7",    3'd7, 32'd100,       32'd7,         32'd2,         1'b0};
    vecs[12] = '{"DIVU_max_1",    3'd5, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[13] = '{"DIVU_5_0",      3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1};
    vecs[14] = '{"REM_5_0",       3'd6, 32'd5,         32'd0,         32'd5,         1'b1};
    vecs[15] = '{"DIV_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vecs[16] = '{"REM_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[17] = '{"DIV_m5_0",      3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1'b1};

    reset_n  = 1'b0;
    start_i  = 1'b0;
    funct3_i = 3'd0;
    op_a_i   = '0;
    op_b_i   = '0;
    flush_i  = 1'b0;
    #1;
    check("reset_stall", 32'(stall_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_result", result_o, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 18; i++) run_vec(vecs[i]);

    // Flush at CALC count 10: back to IDLE, no done, result kept
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd1000; op_b_i = 32'd3;
    @(posedge clk);
    for (int n = 1; n <= 11; n++) begin
      @(negedge clk);
      if (n == 1) start_i = 1'b0;
    end
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush_busy", 32'(busy_o), 32'd0);
    check("flush_stall", 32'(stall_o), 32'd0);
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_o) ndone++;
    end
    check("flush_no_done", 32'(ndone), 32'd0);
    check("flush_result_kept", result_o, last_res);

    // Back-to-back DIVU with start held high through DONE
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd100; op_b_i = 32'd7;
    @(posedge clk);
    ndone = 0; d1 = -1; d2 = -1;
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      #1;
      if (d1 > 0 && n == d1 + 1) check("b2b_accept_stall", 32'(stall_o), 32'd1);
      if (done_o) begin
        if (ndone == 0) begin
          d1 = n;
          check("b2b_res1", result_o, 32'd14);
          check("b2b_done_stall", 32'(stall_o), 32'd0);
          op_a_i = 32'd81; op_b_i = 32'd9;
        end else if (ndone == 1) begin
          d2 = n;
          check("b2b_res2", result_o, 32'd9);
          start_i = 1'b0;
        end
        ndone++;
      end
    end
    check("b2b_done_count", 32'(ndone), 32'd2);
    check("b2b_first_lat", 32'(d1), 32'd33);
    check("b2b_gap", 32'(d2 - d1), 32'd34);

    // Asynchronous reset at CALC count 20
    @(negedge clk);
    start_i = 1'b1; funct3_i = 3'd4; op_a_i = 32'hFFFF_FFEC; op_b_i = 32'd3;
    @(posedge clk);
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      if (n == 1) start_i = 1'b0;
    end
    #1 check("pre_reset_busy", 32'(busy_o), 32'd1);
    reset_n = 1'b0;
    #1;
    check("async_reset_busy", 32'(busy_o), 32'd0);
    check("async_reset_stall", 32'(stall_o), 32'd0);
    check("async_reset_done", 32'(done_o), 32'd0);
    check("async_reset_result", result_o, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_vec(vecs[11]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
